// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers for the EX stage.
// Runs one shift-add or restoring-divide step per cycle, then applies sign correction once.
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            Clk,
  input  logic            rst_n,
  input  logic            Stall,
  input  logic [2:0]      MDop_EX,
  input  logic            MfHi_EX,
  input  logic            MfLo_EX,
  input  logic [XLEN-1:0] RegDataX_EX,
  input  logic [XLEN-1:0] RegDataY_EX,
  output logic [XLEN-1:0] Hi_out,
  output logic [XLEN-1:0] Lo_out,
  output logic            Busy,
  output logic            Stall_MD
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]     opnd_q, opnd_d, xraw_q, xraw_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d, negr_q, negr_d;
  logic                div0_q, div0_d, is_div_q, is_div_d;

  logic signed [XLEN-1:0] x_s, y_s;
  logic                   op_signed;
  logic [XLEN-1:0]        x_mag, y_mag;
  logic [XLEN:0]          mul_sum;
  logic [XLEN:0]          rem_sh;
  logic                   q_bit;
  logic [XLEN-1:0]        rem_sub;
  logic [2*XLEN-1:0]      prod_fix;

  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic is_signed);
    if (is_signed && v[XLEN-1]) return unsigned'(-v);
    return unsigned'(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign x_s       = signed'(RegDataX_EX);
  assign y_s       = signed'(RegDataY_EX);
  assign op_signed = (MDop_EX == OP_MULT) || (MDop_EX == OP_DIV);
  assign x_mag     = magnitude(x_s, op_signed);
  assign y_mag     = magnitude(y_s, op_signed);

  // Shift-add step: the multiplier lives in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Restoring step: remainder shifted left with the next dividend bit pulled in.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign q_bit    = (rem_sh >= {1'b0, opnd_q});
  assign rem_sub  = rem_sh[XLEN-1:0] - opnd_q;
  assign prod_fix = neg_dw(acc_q, neg_q);

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    xraw_d   = xraw_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    case (state_q)
      S_IDLE: begin
        if (!Stall) begin
          case (MDop_EX)
            OP_MTHI: hi_d = RegDataX_EX;
            OP_MTLO: lo_d = RegDataX_EX;
            OP_MULT, OP_MULTU: begin
              state_d  = S_MUL;
              acc_d    = {{XLEN{1'b0}}, y_mag};
              opnd_d   = x_mag;
              neg_d    = op_signed && (x_s[XLEN-1] ^ y_s[XLEN-1]);
              negr_d   = 1'b0;
              div0_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
            end
            OP_DIV, OP_DIVU: begin
              state_d  = S_DIV;
              acc_d    = {{XLEN{1'b0}}, x_mag};
              opnd_d   = y_mag;
              xraw_d   = RegDataX_EX;
              neg_d    = op_signed && (x_s[XLEN-1] ^ y_s[XLEN-1]);
              negr_d   = op_signed && x_s[XLEN-1];
              div0_d   = (RegDataY_EX == '0);
              is_div_d = 1'b1;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {(q_bit ? rem_sub : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], q_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = xraw_q;
          lo_d = '1;
        end else begin
          lo_d = neg_w(acc_q[XLEN-1:0], neg_q);
          hi_d = neg_w(acc_q[2*XLEN-1:XLEN], negr_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      xraw_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      xraw_q   <= xraw_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
    end
  end

  assign Hi_out   = hi_q;
  assign Lo_out   = lo_q;
  assign Busy     = (state_q != S_IDLE);
  assign Stall_MD = Busy && (((MDop_EX != 3'd0) && (MDop_EX != 3'd7)) || MfHi_EX || MfLo_EX);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: a behavioural HI/LO model queues expected results per op.
module tb_muldiv_ctrl;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic [2:0]  MDop_EX;
  logic        MfHi_EX, MfLo_EX;
  logic [31:0] RegDataX_EX, RegDataY_EX;
  logic [31:0] Hi_out, Lo_out;
  logic        Busy, Stall_MD;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .Clk(Clk), .rst_n(rst_n), .Stall(Stall), .MDop_EX(MDop_EX),
    .MfHi_EX(MfHi_EX), .MfLo_EX(MfLo_EX),
    .RegDataX_EX(RegDataX_EX), .RegDataY_EX(RegDataY_EX),
    .Hi_out(Hi_out), .Lo_out(Lo_out), .Busy(Busy), .Stall_MD(Stall_MD)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, y);
    int ix, iy, q, r;
    longint sx, sy;
    ix = x; iy = y; sx = ix; sy = iy;
    case (op)
      3'd1: return sx * sy;
      3'd2: return {32'b0, x} * {32'b0, y};
      3'd3: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = ix / iy; r = ix % iy;
        return {r, q};
      end
      3'd4: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      3'd5: return {x, lo_m};
      3'd6: return {hi_m, x};
      default: return {hi_m, lo_m};
    endcase
  endfunction

  task automatic push_exp(input logic [2:0] op, input logic [31:0] x, y);
    logic [63:0] e;
    e = model(op, x, y);
    hi_m = e[63:32];
    lo_m = e[31:0];
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, y);
    @(negedge Clk);
    Stall = 1'b0; MDop_EX = op; RegDataX_EX = x; RegDataY_EX = y;
    push_exp(op, x, y);
    @(negedge Clk);
    MDop_EX = 3'd0;
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (Busy && c < 100) begin
      c++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Stall = 1'b0; MDop_EX = 3'd0; MfHi_EX = 1'b0; MfLo_EX = 1'b0;
    RegDataX_EX = 32'h0; RegDataY_EX = 32'h0;
    repeat (2) @(negedge Clk);
    n_tests++; if (Hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", Hi_out); end
    n_tests++; if (Lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", Lo_out); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++; if (Stall_MD !== 1'b0) begin n_fail++; $display("FAIL reset_stall_md: got %b want 0", Stall_MD); end
    rst_n = 1'b1;
  endtask

  task automatic test_muldiv_table();
    logic [2:0]  ops[12] = '{3'd1, 3'd2, 3'd1, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd3,
                             3'd4, 3'd3, 3'd3};
    logic [31:0] xs[12]  = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd0, 32'd100,
                             32'hFFFFFFF9, 32'd7, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFF9};
    logic [31:0] ys[12]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'd12345, 32'd7,
                             32'd2, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9};
    logic [63:0] e;
    int c;
    for (int i = 0; i < 12; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_idle(c);
      e = exp_q.pop_front();
      n_tests++; if (c !== 33) begin n_fail++; $display("FAIL op%0d_busy_cycles: got %0d want 33", i, c); end
      n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL op%0d_hi: got %h want %h", i, Hi_out, e[63:32]); end
      n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL op%0d_lo: got %h want %h", i, Lo_out, e[31:0]); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] e;
    issue(3'd5, 32'hDEADBEEF, 32'h0);
    e = exp_q.pop_front();
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", Busy); end
    n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL mthi_hi: got %h want %h", Hi_out, e[63:32]); end
    issue(3'd6, 32'h12345678, 32'h0);
    e = exp_q.pop_front();
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL mtlo_lo: got %h want %h", Lo_out, e[31:0]); end
    n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want %h", Hi_out, e[63:32]); end
  endtask

  task automatic test_stall_md();
    logic [63:0] e;
    int c;
    @(negedge Clk);
    MDop_EX = 3'd1; RegDataX_EX = 32'd3; RegDataY_EX = 32'd4;
    push_exp(3'd1, 32'd3, 32'd4);
    @(negedge Clk);
    MDop_EX = 3'd0;
    #1;
    n_tests++; if (Stall_MD !== 1'b0) begin n_fail++; $display("FAIL smd_no_request: got %b want 0", Stall_MD); end
    @(negedge Clk);
    MfLo_EX = 1'b1;
    #1;
    c = 0;
    while (Stall_MD && c < 100) begin
      c++;
      @(negedge Clk);
      #1;
    end
    e = exp_q.pop_front();
    n_tests++; if (c !== 32) begin n_fail++; $display("FAIL smd_cycles: got %0d want 32", c); end
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL smd_mflo_lo: got %h want %h", Lo_out, e[31:0]); end
    n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL smd_hi: got %h want %h", Hi_out, e[63:32]); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL smd_busy_after: got %b want 0", Busy); end
    MfLo_EX = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    int c;
    issue(3'd2, 32'd5, 32'd6);
    MDop_EX = 3'd4; RegDataX_EX = 32'd100; RegDataY_EX = 32'd7;
    push_exp(3'd4, 32'd100, 32'd7);
    #1;
    n_tests++; if (Stall_MD !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_md: got %b want 1", Stall_MD); end
    wait_idle(c);
    e = exp_q.pop_front();
    n_tests++; if (c !== 33) begin n_fail++; $display("FAIL b2b_first_cycles: got %0d want 33", c); end
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL b2b_first_lo: got %h want %h", Lo_out, e[31:0]); end
    n_tests++; if (Stall_MD !== 1'b0) begin n_fail++; $display("FAIL b2b_release: got %b want 0", Stall_MD); end
    @(negedge Clk);
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_e34: got %b want 1", Busy); end
    MDop_EX = 3'd0;
    wait_idle(c);
    e = exp_q.pop_front();
    n_tests++; if (c !== 33) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d want 33", c); end
    n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL b2b_second_hi: got %h want %h", Hi_out, e[63:32]); end
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL b2b_second_lo: got %h want %h", Lo_out, e[31:0]); end
  endtask

  task automatic test_stall_input();
    logic [63:0] e;
    logic [31:0] lo_old;
    int c;
    lo_old = lo_m;
    @(negedge Clk);
    Stall = 1'b1; MDop_EX = 3'd6; RegDataX_EX = 32'd9;
    repeat (3) @(negedge Clk);
    n_tests++; if (Lo_out !== lo_old) begin n_fail++; $display("FAIL stall_mtlo_held: got %h want %h", Lo_out, lo_old); end
    Stall = 1'b0;
    push_exp(3'd6, 32'd9, 32'd0);
    @(negedge Clk);
    MDop_EX = 3'd0;
    e = exp_q.pop_front();
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL stall_mtlo_release: got %h want %h", Lo_out, e[31:0]); end
    Stall = 1'b1; MDop_EX = 3'd1; RegDataX_EX = 32'd2; RegDataY_EX = 32'd2;
    repeat (2) @(negedge Clk);
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL stall_no_start: got %b want 0", Busy); end
    Stall = 1'b0;
    push_exp(3'd1, 32'd2, 32'd2);
    @(negedge Clk);
    MDop_EX = 3'd0;
    Stall = 1'b1;
    wait_idle(c);
    Stall = 1'b0;
    e = exp_q.pop_front();
    n_tests++; if (c !== 33) begin n_fail++; $display("FAIL stall_iter_cycles: got %0d want 33", c); end
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL stall_iter_lo: got %h want %h", Lo_out, e[31:0]); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    int c;
    @(negedge Clk);
    MDop_EX = 3'd3; RegDataX_EX = 32'd1000; RegDataY_EX = 32'd3;
    @(negedge Clk);
    MDop_EX = 3'd0;
    repeat (9) @(negedge Clk);
    rst_n = 1'b0;
    #1;
    hi_m = 32'h0; lo_m = 32'h0;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", Busy); end
    n_tests++; if (Hi_out !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h want 0", Hi_out); end
    n_tests++; if (Lo_out !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h want 0", Lo_out); end
    @(negedge Clk);
    rst_n = 1'b1;
    issue(3'd2, 32'd2, 32'd3);
    wait_idle(c);
    e = exp_q.pop_front();
    n_tests++; if (c !== 33) begin n_fail++; $display("FAIL midrst_multu_cycles: got %0d want 33", c); end
    n_tests++; if (Lo_out !== e[31:0]) begin n_fail++; $display("FAIL midrst_multu_lo: got %h want %h", Lo_out, e[31:0]); end
    n_tests++; if (Hi_out !== e[63:32]) begin n_fail++; $display("FAIL midrst_multu_hi: got %h want %h", Hi_out, e[63:32]); end
  endtask

  task automatic test_random();
    logic [63:0] e;
    logic [2:0]  op;
    logic [31:0] x, y;
    int c;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(1, 4));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(op, x, y);
      wait_idle(c);
      e = exp_q.pop_front();
      n_tests++; if (c !== 33) begin n_fail++; $display("FAIL rnd%0d_cycles: got %0d want 33", i, c); end
      n_tests++; if ({Hi_out, Lo_out} !== e) begin n_fail++; $display("FAIL rnd%0d_op%0d x=%h y=%h: got %h want %h", i, op, x, y, {Hi_out, Lo_out}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_muldiv_table();
    test_mthi_mtlo();
    test_stall_md();
    test_back_to_back();
    test_stall_input();
    test_reset_mid();
    test_random();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
